// File: rtl/div_issue_ctrl_if.sv
// EX-stage <-> divider bundle for div_issue_ctrl. The master modport is the controller side.
// div_zero_o exists only when DIV_ZERO_TRAP_EN is defined.
interface div_issue_ctrl_if;
  // EX side
  logic        div_op_i;
  logic        signed_i;
  logic [15:0] opa_i;
  logic [15:0] opb_i;
  logic        flush_i;
  // Divider side
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [15:0] div_op1_o;
  logic [15:0] div_op2_o;
  logic [31:0] div_result_i;
  logic        div_ready_i;
  // Pipeline / write-back side
  logic        stall_req_o;
  logic        hilo_we_o;
  logic [15:0] hi_o;
  logic [15:0] lo_o;
  logic        timeout_o;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero_o;
`endif
  // FSM debug view: 0 = IDLE, 1 = BUSY, 2 = DONE
  logic [1:0]  state_dbg_o;

  modport master (
`ifdef DIV_ZERO_TRAP_EN
    output div_zero_o,
`endif
    input  div_op_i, signed_i, opa_i, opb_i, flush_i,
    input  div_result_i, div_ready_i,
    output div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
    output stall_req_o, hilo_we_o, hi_o, lo_o, timeout_o,
    output state_dbg_o
  );

  modport slave (
`ifdef DIV_ZERO_TRAP_EN
    input  div_zero_o,
`endif
    output div_op_i, signed_i, opa_i, opb_i, flush_i,
    output div_result_i, div_ready_i,
    input  div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
    input  stall_req_o, hilo_we_o, hi_o, lo_o, timeout_o,
    input  state_dbg_o
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the 16-bit iterative divider: latch, start, stall, write back HI/LO.
// Optional DIV_ZERO_TRAP_EN: a zero divisor is refused in IDLE and reported on div_zero_o.
module div_issue_ctrl #(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic             clk,
  input  logic             rst,
  div_issue_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: div_start_o is held high for the whole BUSY phase; the divider
  // answers with a one-cycle div_ready_i, and div_start_o drops the next cycle
  // (DONE), which frees the divider. div_annul_o cancels an in-flight divide.

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      op1_q, op1_d;
  logic [15:0]      op2_q, op2_d;
  logic             sgn_q, sgn_d;
  logic [15:0]      hi_q, hi_d;
  logic [15:0]      lo_q, lo_d;

  logic start, annul, stall, we, tmo;
  logic zero_div;
  logic accept;
  logic wd_expired;

`ifdef DIV_ZERO_TRAP_EN
  assign zero_div = (bus.opb_i == 16'd0);
  assign bus.div_zero_o = (state_q == S_IDLE) & bus.div_op_i & ~bus.flush_i & zero_div;
`else
  assign zero_div = 1'b0;
`endif

  assign accept     = (state_q == S_IDLE) & bus.div_op_i & ~bus.flush_i & ~zero_div;
  assign wd_expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start   = 1'b0;
    annul   = 1'b0;
    stall   = 1'b0;
    we      = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op1_d   = bus.opa_i;
          op2_d   = bus.opb_i;
          sgn_d   = bus.signed_i;
          cnt_d   = '0;
          stall   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // Flush wins over a same-cycle result; the watchdog only fires without one.
        if (bus.flush_i) begin
          annul   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.div_ready_i) begin
          start   = 1'b1;
          stall   = 1'b1;
          hi_d    = bus.div_result_i[31:16];
          lo_d    = bus.div_result_i[15:0];
          state_d = S_DONE;
        end else if (wd_expired) begin
          annul   = 1'b1;
          tmo     = 1'b1;
          state_d = S_IDLE;
        end else begin
          start = 1'b1;
          stall = 1'b1;
        end
      end
      S_DONE: begin
        we      = ~bus.flush_i;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.div_start_o  = start;
  assign bus.div_annul_o  = annul;
  assign bus.div_signed_o = sgn_q;
  assign bus.div_op1_o    = op1_q;
  assign bus.div_op2_o    = op2_q;
  assign bus.stall_req_o  = stall;
  assign bus.hilo_we_o    = we;
  assign bus.hi_o         = hi_q;
  assign bus.lo_o         = lo_q;
  assign bus.timeout_o    = tmo;
  assign bus.state_dbg_o  = state_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed vector table, hand sequences and random traffic,
// all checked cycle by cycle against a transaction-level model plus a write-back queue.
module tb_div_issue_ctrl;
  localparam int TIMEOUT_CYC = 32;
  localparam int DIV_LAT     = 19;  // start cycles seen before the divider raises ready

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_issue_ctrl_if bus_if ();
  div_issue_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [31:0] exp_q[$];

  // Reference model: an outstanding divide and its age in cycles since acceptance.
  bit          m_active, m_wb;
  int          m_age;
  logic [15:0] m_op1, m_op2;
  logic        m_sgn;
  logic [31:0] m_hilo;

  // Divider emulation
  int dv_cnt;
  bit dv_hang, dv_noise;

  // Sampled DUT outputs of the last stepped cycle
  logic       s_start, s_annul, s_stall, s_we, s_to, s_zero;
  logic [1:0] s_state;

  typedef struct {
    logic [15:0] a, b;
    logic        s;
    logic [15:0] hi, lo;
    int          lat;
    int          stalls;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  function automatic logic [31:0] div_fn(input logic [15:0] a, input logic [15:0] b, input logic s);
    int q, r, sa, sb;
    if (b == 16'd0) return 32'h0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
    end
    return {r[15:0], q[15:0]};
  endfunction

  task automatic model_reset();
    m_active = 0; m_wb = 0; m_age = 0;
    m_op1 = '0; m_op2 = '0; m_sgn = 1'b0; m_hilo = '0;
    exp_q.delete();
  endtask

  // Expected behaviour of the current cycle from the current inputs, then advance.
  task automatic model_cycle();
    bit e_start = 0, e_annul = 0, e_stall = 0, e_we = 0, e_to = 0, e_zero = 0;
    logic [1:0] e_state;
    bit n_active = m_active, n_wb = 0;
    int n_age = m_age + 1;
    logic [31:0] n_hilo = m_hilo;
    logic [31:0] wb;
    e_state = m_wb ? 2'd2 : (m_active ? 2'd1 : 2'd0);
    if (m_wb) begin
      e_we = !bus_if.flush_i;
      wb = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      if (e_we) chk("wb_data", {bus_if.hi_o, bus_if.lo_o}, wb);
    end else if (m_active) begin
      if (bus_if.flush_i) begin
        e_annul = 1; n_active = 0;
      end else if (bus_if.div_ready_i) begin
        e_start = 1; e_stall = 1; n_active = 0; n_wb = 1;
        n_hilo = bus_if.div_result_i;
        exp_q.push_back(bus_if.div_result_i);
      end else if (m_age == TIMEOUT_CYC) begin
        e_annul = 1; e_to = 1; n_active = 0;
      end else begin
        e_start = 1; e_stall = 1;
      end
    end else if (bus_if.div_op_i && !bus_if.flush_i) begin
`ifdef DIV_ZERO_TRAP_EN
      if (bus_if.opb_i == 16'd0) e_zero = 1;
      else begin
`else
      begin
`endif
        e_stall = 1; n_active = 1; n_age = 1;
        m_op1 = bus_if.opa_i; m_op2 = bus_if.opb_i; m_sgn = bus_if.signed_i;
      end
    end
    chk("start", s_start, e_start);
    chk("annul", s_annul, e_annul);
    chk("stall", s_stall, e_stall);
    chk("hilo_we", s_we, e_we);
    chk("timeout", s_to, e_to);
    chk("div_zero", s_zero, e_zero);
    chk("state", s_state, e_state);
    chk("hi_lo_hold", {bus_if.hi_o, bus_if.lo_o}, m_hilo);
    if (e_state != 2'd0 || !n_active) begin
      chk("op1", bus_if.div_op1_o, m_op1);
      chk("op2", bus_if.div_op2_o, m_op2);
      chk("signed", bus_if.div_signed_o, m_sgn);
    end
    m_active = n_active; m_wb = n_wb; m_age = n_age; m_hilo = n_hilo;
  endtask

  task automatic step();
    logic rdy;
    @(negedge clk);
    s_start = bus_if.div_start_o;
    s_annul = bus_if.div_annul_o;
    s_stall = bus_if.stall_req_o;
    s_we    = bus_if.hilo_we_o;
    s_to    = bus_if.timeout_o;
    s_state = bus_if.state_dbg_o;
`ifdef DIV_ZERO_TRAP_EN
    s_zero  = bus_if.div_zero_o;
`else
    s_zero  = 1'b0;
`endif
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (s_start) dv_cnt++;
    else dv_cnt = 0;
    rdy = 1'b0;
    if (!dv_hang && dv_cnt == DIV_LAT) rdy = 1'b1;
    else if (dv_noise && !s_start && $urandom_range(0, 9) == 0) rdy = 1'b1;
    bus_if.div_ready_i  = rdy;
    bus_if.div_result_i = rdy ? div_fn(bus_if.div_op1_o, bus_if.div_op2_o, bus_if.div_signed_o)
                              : $urandom();
  endtask

  task automatic idle_inputs();
    bus_if.div_op_i = 1'b0;
    bus_if.signed_i = 1'b0;
    bus_if.opa_i    = 16'h0;
    bus_if.opb_i    = 16'h0;
    bus_if.flush_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    bus_if.div_ready_i  = 1'b0;
    bus_if.div_result_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dv_cnt = 0;
    model_reset();
  endtask

  task automatic run_div(input vec_t v, input string tag);
    int we_cyc = -1;
    int stall_n = 0;
    bus_if.div_op_i = 1'b1;
    bus_if.opa_i    = v.a;
    bus_if.opb_i    = v.b;
    bus_if.signed_i = v.s;
    bus_if.flush_i  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k == 0) begin
`ifdef DIV_ZERO_TRAP_EN
        if (v.b == 16'd0) chk({tag, "_zero_pulse"}, s_zero, 1'b1);
`endif
        bus_if.div_op_i = 1'b0;
        bus_if.opa_i    = 16'($urandom());
        bus_if.opb_i    = 16'($urandom());
        bus_if.signed_i = 1'($urandom());
      end
      if (s_stall) stall_n++;
      if (s_we) begin
        we_cyc = k;
        chk({tag, "_hi"}, bus_if.hi_o, v.hi);
        chk({tag, "_lo"}, bus_if.lo_o, v.lo);
        break;
      end
    end
    chk({tag, "_latency"}, we_cyc, v.lat);
    chk({tag, "_stall_cycles"}, stall_n, v.stalls);
    idle_inputs();
  endtask

  initial begin
    int to_cyc, we_n;
    dv_hang = 0; dv_noise = 0; dv_cnt = 0;
    vecs[0] = '{16'h0064, 16'h0007, 1'b0, 16'h0002, 16'h000E, 21, 21};
    vecs[1] = '{16'hFF9C, 16'h0007, 1'b1, 16'hFFFE, 16'hFFF2, 21, 21};
    vecs[2] = '{16'h1234, 16'h0010, 1'b0, 16'h0004, 16'h0123, 21, 21};
    vecs[3] = '{16'h8000, 16'h0003, 1'b0, 16'h0002, 16'h2AAA, 21, 21};
`ifdef DIV_ZERO_TRAP_EN
    vecs[4] = '{16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000, -1, 0};
`else
    vecs[4] = '{16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000, 21, 21};
`endif
    vecs[5] = '{16'h00FF, 16'h0010, 1'b0, 16'h000F, 16'h000F, 21, 21};

    do_reset();
    step();
    chk("reset_state", s_state, 2'd0);
    chk("reset_strobes", {s_start, s_annul, s_stall, s_we, s_to}, 5'b0);
    chk("reset_hilo", {bus_if.hi_o, bus_if.lo_o}, 32'h0);

    // Directed table; entries 2 and 3 run back to back (pulses at cycles 21 and 43).
    for (int i = 0; i < 5; i++) run_div(vecs[i], $sformatf("vec%0d", i));

    // Flush at cycle 10, then a normal divide.
    bus_if.div_op_i = 1'b1; bus_if.opa_i = 16'h4321; bus_if.opb_i = 16'h0005;
    step();
    idle_inputs();
    repeat (9) step();
    bus_if.flush_i = 1'b1;
    bus_if.div_ready_i = 1'b1;
    step();
    chk("flush_annul", s_annul, 1'b1);
    chk("flush_stall", s_stall, 1'b0);
    bus_if.flush_i = 1'b0;
    we_n = 0;
    repeat (25) begin step(); if (s_we) we_n++; end
    chk("flush_no_write", we_n, 0);
    run_div(vecs[5], "after_flush");

    // Flush during DONE suppresses the write.
    bus_if.div_op_i = 1'b1; bus_if.opa_i = 16'h0100; bus_if.opb_i = 16'h0003;
    step();
    idle_inputs();
    repeat (20) step();
    bus_if.flush_i = 1'b1;
    step();
    chk("done_flush_we", s_we, 1'b0);
    bus_if.flush_i = 1'b0;

    // Watchdog: divider never answers.
    dv_hang = 1;
    to_cyc = -1;
    bus_if.div_op_i = 1'b1; bus_if.opa_i = 16'h7777; bus_if.opb_i = 16'h0011;
    step();
    idle_inputs();
    for (int k = 1; k < 45; k++) begin
      step();
      if (s_to) begin
        to_cyc = k;
        chk("wd_annul", s_annul, 1'b1);
        break;
      end
    end
    chk("wd_cycle", to_cyc, 32);
    step();
    chk("wd_idle", s_state, 2'd0);
    chk("wd_no_write", s_we, 1'b0);
    dv_hang = 0;

    // Reset mid-operation: no write afterwards, registers cleared.
    bus_if.div_op_i = 1'b1; bus_if.opa_i = 16'h0999; bus_if.opb_i = 16'h0007;
    step();
    idle_inputs();
    repeat (5) step();
    do_reset();
    we_n = 0;
    repeat (25) begin step(); if (s_we) we_n++; end
    chk("rst_mid_no_write", we_n, 0);
    chk("rst_mid_op1", bus_if.div_op1_o, 16'h0);

    // Random traffic against the model.
    dv_noise = 1;
    for (int k = 0; k < 800; k++) begin
      bus_if.div_op_i = ($urandom_range(0, 1) == 1);
      bus_if.flush_i  = ($urandom_range(0, 31) == 0);
      bus_if.signed_i = 1'($urandom());
      bus_if.opa_i    = 16'($urandom());
      bus_if.opb_i    = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom());
      step();
    end
    dv_noise = 0;
    idle_inputs();
    repeat (30) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end
endmodule
